// File: rtl/lshift_seq.sv
// Iterative left shifter: shifts portA left by min(portB, WIDTH) one bit per clock.
// Build with LSHIFT_CARRY_EN defined to add the registered overflow output carry.
//
// state  | meaning
// IDLE   | waiting for init; out holds the last result
// SHIFT  | shifting acc one position per clock until cnt reaches zero
// FINISH | DONE high; waiting for init to drop before accepting another op
module lshift_seq #(
  parameter int WIDTH = 3,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] portA,
  input  logic [SHW-1:0]   portB,
  output logic [WIDTH-1:0] out,
  output logic             DONE,
  output logic             busy
`ifdef LSHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_load;

  // Saturate the shift amount so any portB >= WIDTH clears every bit.
  always_comb begin
    cnt_load = CW'(WIDTH);
    if (32'(portB) < 32'(WIDTH)) cnt_load = CW'(portB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      DONE  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            acc   <= portA;
            cnt   <= cnt_load;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - CW'(1);
          end else begin
            out   <= acc;
            DONE  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH: begin
          // Requester must be seen low before another op can start.
          if (!init) begin
            DONE  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSHIFT_CARRY_EN
  logic lost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost  <= 1'b0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            lost  <= 1'b0;
            carry <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            if (acc[WIDTH-1]) lost <= 1'b1;
          end else begin
            carry <= lost;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lshift_seq.sv
// Self-checking bench for lshift_seq: per-cycle model comparison plus directed literal checks.
// Define LSHIFT_CARRY_EN to also check the carry output.
module tb_lshift_seq;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic [W-1:0] portA;
  logic [2:0]   portB;
  logic [W-1:0] out;
  logic         DONE;
  logic         busy;
`ifdef LSHIFT_CARRY_EN
  logic         carry;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  lshift_seq #(.WIDTH(W), .SHW(3)) dut (
    .clk(clk), .rst(rst), .init(init), .portA(portA), .portB(portB),
    .out(out), .DONE(DONE), .busy(busy)
`ifdef LSHIFT_CARRY_EN
    , .carry(carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: result computed arithmetically, timing by cycle countdown.
  bit           m_active, m_done, m_carry, m_cpend;
  int           m_left;
  logic [W-1:0] m_res, m_out;

  always @(posedge clk or posedge rst) begin
    int unsigned n;
    int unsigned wide;
    if (rst) begin
      m_active = 0; m_done = 0; m_carry = 0; m_cpend = 0;
      m_left = 0; m_res = '0; m_out = '0;
    end else if (m_active) begin
      if (m_left == 0) begin
        m_active = 0; m_done = 1; m_out = m_res; m_carry = m_cpend;
      end else begin
        m_left--;
      end
    end else if (m_done) begin
      if (!init) m_done = 0;
    end else if (init) begin
      n = (int'(portB) > W) ? W : int'(portB);
      wide = int'(portA) << n;
      m_res = wide[W-1:0];
      m_cpend = (wide >> W) != 0;
      m_left = int'(n);
      m_active = 1;
      m_carry = 0;
    end
    #1;
    if (chk_en) begin
      chk("cyc_out", 32'(out), 32'(m_out));
      chk("cyc_done", 32'(DONE), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_active));
`ifdef LSHIFT_CARRY_EN
      chk("cyc_carry", 32'(carry), 32'(m_carry));
`endif
    end
  end

  task automatic edge_n(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [2:0] b);
    @(negedge clk);
    portA = a; portB = b; init = 1'b1;
  endtask

  task automatic drop_init();
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; init = 1'b0; portA = '0; portB = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_busy", 32'(busy), 0);

    // 3 << 1
    start(3'd3, 3'd1);
    edge_n(1);
    chk("t1_busy_e0", 32'(busy), 1);
    edge_n(2);
    chk("t1_out", 32'(out), 6);
    chk("t1_done", 32'(DONE), 1);
    chk("t1_model_out", 32'(m_out), 6);
`ifdef LSHIFT_CARRY_EN
    chk("t1_carry", 32'(carry), 0);
`endif
    drop_init();
    edge_n(1);
    chk("t1_done_drop", 32'(DONE), 0);

    // 6 << 2 overflows to 0, init held in FINISH
    start(3'd6, 3'd2);
    edge_n(3);
    chk("t2_done_e2", 32'(DONE), 0);
    edge_n(1);
    chk("t2_out", 32'(out), 0);
    chk("t2_done", 32'(DONE), 1);
`ifdef LSHIFT_CARRY_EN
    chk("t2_carry", 32'(carry), 1);
    chk("t2_model_carry", 32'(m_carry), 1);
`endif
    for (int i = 0; i < 5; i++) begin
      edge_n(1);
      chk("t2_done_hold", 32'(DONE), 1);
    end
    drop_init();
    edge_n(1);
    chk("t2_done_drop", 32'(DONE), 0);

    // zero shift: single busy cycle
    start(3'd5, 3'd0);
    edge_n(1);
    chk("t3_busy_e0", 32'(busy), 1);
    edge_n(1);
    chk("t3_out", 32'(out), 5);
    chk("t3_done", 32'(DONE), 1);
    chk("t3_busy_e1", 32'(busy), 0);
    chk("t3_model_out", 32'(m_out), 5);
    drop_init();
    edge_n(1);

    // saturating shift, operands changed mid-op
    start(3'd7, 3'd7);
    edge_n(1);
    @(negedge clk);
    portA = 3'd1; portB = 3'd1;
    edge_n(3);
    chk("t4_done_e3", 32'(DONE), 0);
    chk("t4_busy_e3", 32'(busy), 1);
    edge_n(1);
    chk("t4_out", 32'(out), 0);
    chk("t4_done", 32'(DONE), 1);
    chk("t4_model_done", 32'(m_done), 1);
    drop_init();
    edge_n(1);

    // back-to-back ops
    start(3'd1, 3'd2);
    edge_n(3);
    chk("t6a_done_e2", 32'(DONE), 0);
    edge_n(1);
    chk("t6a_out", 32'(out), 4);
    chk("t6a_done", 32'(DONE), 1);
    drop_init();
    edge_n(1);
    chk("t6_gap_done", 32'(DONE), 0);
    edge_n(1);
    chk("t6_gap_done2", 32'(DONE), 0);
    start(3'd2, 3'd1);
    edge_n(2);
    chk("t6b_done_e1", 32'(DONE), 0);
    edge_n(1);
    chk("t6b_out", 32'(out), 4);
    chk("t6b_done", 32'(DONE), 1);
    drop_init();
    edge_n(1);
    chk("t6b_done_drop", 32'(DONE), 0);

    // one-cycle init pulse: op completes, DONE for one cycle
    start(3'd1, 3'd1);
    @(posedge clk);
    drop_init();
    edge_n(2);
    chk("t7_out", 32'(out), 2);
    chk("t7_done", 32'(DONE), 1);
    edge_n(1);
    chk("t7_done_once", 32'(DONE), 0);
    chk("t7_out_hold", 32'(out), 2);

    // async reset mid-SHIFT, then fresh op with init still high
    start(3'd3, 3'd3);
    edge_n(3);
    rst = 1'b1;
    #1;
    chk("t5_rst_out", 32'(out), 0);
    chk("t5_rst_done", 32'(DONE), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_n(1);
    chk("t5_busy_e0", 32'(busy), 1);
    edge_n(3);
    chk("t5_done_e3", 32'(DONE), 0);
    edge_n(1);
    chk("t5_out", 32'(out), 0);
    chk("t5_done", 32'(DONE), 1);
`ifdef LSHIFT_CARRY_EN
    chk("t5_carry", 32'(carry), 1);
`endif
    drop_init();
    edge_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
